// File: rtl/hd_transfer_controller.sv
// Sequencer that moves a run of words between the hard drive and data memory,
// walking track/sector and memory address once per cycle.
module hd_transfer_controller #(
    parameter int DATA_W            = 32,
    parameter int TRACK_W           = 7,
    parameter int SECTOR_W          = 14,
    parameter int MEM_AW            = 10,
    parameter int SECTORS_PER_TRACK = 151,
    parameter int NUM_TRACKS        = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                direction,
    input  logic [TRACK_W-1:0]  track_in,
    input  logic [SECTOR_W-1:0] sector_in,
    input  logic [MEM_AW-1:0]   mem_base,
    input  logic [7:0]          length,
    input  logic [DATA_W-1:0]   output_hard_drive,
    input  logic [DATA_W-1:0]   mem_data_read,
    output logic [TRACK_W-1:0]  track,
    output logic [SECTOR_W-1:0] sector,
    output logic [DATA_W-1:0]   data_write,
    output logic                flag_write_hd,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_data_write,
    output logic                mem_write,
    output logic                busy,
    output logic                done,
    output logic                error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [TRACK_W:0]    NUM_TRACKS_L  = (TRACK_W+1)'(NUM_TRACKS);
    localparam logic [SECTOR_W:0]   NUM_SECTORS_L = (SECTOR_W+1)'(SECTORS_PER_TRACK);
    localparam logic [SECTOR_W-1:0] LAST_SECTOR   = SECTOR_W'(SECTORS_PER_TRACK - 1);

    state_t              state_q,  state_d;
    logic                dir_q,    dir_d;
    logic [7:0]          count_q,  count_d;
    logic [TRACK_W-1:0]  track_q,  track_d;
    logic [SECTOR_W-1:0] sector_q, sector_d;
    logic [MEM_AW-1:0]   addr_q,   addr_d;

    logic                start_bad;
    logic [TRACK_W:0]    track_inc;
    logic                track_overflow;

    assign start_bad      = ({1'b0, track_in} >= NUM_TRACKS_L) ||
                            ({1'b0, sector_in} >= NUM_SECTORS_L);
    assign track_inc      = {1'b0, track_q} + {{TRACK_W{1'b0}}, 1'b1};
    assign track_overflow = (track_inc >= NUM_TRACKS_L);

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        count_d  = count_q;
        track_d  = track_q;
        sector_d = sector_q;
        addr_d   = addr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_bad) begin
                        state_d = ERR;
                    end else if (length == 8'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = XFER;
                        dir_d    = direction;
                        count_d  = length;
                        track_d  = track_in;
                        sector_d = sector_in;
                        addr_d   = mem_base;
                    end
                end
            end
            XFER: begin
                count_d = count_q - 8'd1;
                // The final word leaves the address outputs on the last location moved.
                if (count_q == 8'd1) begin
                    state_d = DONE;
                end else if (sector_q == LAST_SECTOR) begin
                    if (track_overflow) begin
                        state_d = ERR;
                    end else begin
                        sector_d = '0;
                        track_d  = track_q + 1'b1;
                        addr_d   = addr_q + 1'b1;
                    end
                end else begin
                    sector_d = sector_q + 1'b1;
                    addr_d   = addr_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            dir_q    <= 1'b0;
            count_q  <= '0;
            track_q  <= '0;
            sector_q <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            count_q  <= count_d;
            track_q  <= track_d;
            sector_q <= sector_d;
            addr_q   <= addr_d;
        end
    end

    // Strobes decode straight from state flops; data outputs are forced to zero
    // whenever their strobe is low so nothing stale leaks onto either bus.
    assign mem_write      = (state_q == XFER) && !dir_q;
    assign flag_write_hd  = (state_q == XFER) &&  dir_q;
    assign mem_data_write = mem_write     ? output_hard_drive : '0;
    assign data_write     = flag_write_hd ? mem_data_read     : '0;
    assign track          = track_q;
    assign sector         = sector_q;
    assign mem_addr       = addr_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign error          = (state_q == ERR);

endmodule

// File: doc/hd_transfer_controller.md
HD_TRANSFER_CONTROLLER -- requirements
Module: hd_transfer_controller

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the word width.
REQ-002 The block SHALL have parameter TRACK_W, default 7, meaning the track address width.
REQ-003 The block SHALL have parameter SECTOR_W, default 14, meaning the sector address width.
REQ-004 The block SHALL have parameter MEM_AW, default 10, meaning the data-memory address width.
REQ-005 The block SHALL have parameter SECTORS_PER_TRACK, default 151, meaning the number of valid sectors per track.
REQ-006 The block SHALL have parameter NUM_TRACKS, default 3, meaning the number of valid tracks.
REQ-007 The block SHALL use one clock and a synchronous, active-high reset, with ports clock and reset.
REQ-008 The ports SHALL be as follows (name, direction, width, meaning):
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  transfer request, sampled in IDLE.
- direction  in  1  0 = load (HD->memory), 1 = store (memory->HD).
- track_in  in  TRACK_W  start track.
- sector_in  in  SECTOR_W  start sector.
- mem_base  in  MEM_AW  start memory address.
- length  in  8  word count, 0..255.
- output_hard_drive  in  DATA_W  HD read data, combinational on track/sector.
- mem_data_read  in  DATA_W  memory read data, combinational on mem_addr.
- track  out  TRACK_W  HD track address.
- sector  out  SECTOR_W  HD sector address.
- data_write  out  DATA_W  HD write data.
- flag_write_hd  out  1  HD write strobe.
- mem_addr  out  MEM_AW  memory address.
- mem_data_write  out  DATA_W  memory write data.
- mem_write  out  1  memory write strobe.
- busy  out  1  high when the FSM is not in IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle pulse on aborted transfer.

Function
REQ-009 The FSM SHALL have states IDLE, XFER, DONE and ERR, all registered.
REQ-010 In IDLE with start=1, the block SHALL latch direction, track_in, sector_in, mem_base and length into working registers and go to XFER, or to DONE if length=0.
REQ-011 If track_in>=NUM_TRACKS or sector_in>=SECTORS_PER_TRACK at start, the block SHALL go to ERR without any strobe.
REQ-012 In XFER the block SHALL move one word per cycle: track/sector = working counters; mem_addr = working memory address.
REQ-013 Load: mem_write=1 and mem_data_write=output_hard_drive in the same cycle; flag_write_hd=0.
REQ-014 Store: flag_write_hd=1 and data_write=mem_data_read in the same cycle; mem_write=0.
REQ-015 After each XFER word the block SHALL increment the sector; when sector=SECTORS_PER_TRACK-1 it SHALL wrap the sector to 0 and increment the track.
REQ-016 mem_addr SHALL increment modulo 2^MEM_AW, wrapping silently.
REQ-017 The remaining count SHALL decrement per word; after the last word (count 1->0) the next state SHALL be DONE.
REQ-018 If a sector wrap would move the track to NUM_TRACKS while the count is still >0, the next state SHALL be ERR; words already moved stay moved.
REQ-019 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE; ERR SHALL assert error=1 for one cycle, then return to IDLE.
REQ-020 start outside IDLE SHALL be ignored, with no queuing; input changes during a transfer SHALL have no effect.
REQ-021 busy SHALL be 1 in XFER, DONE and ERR.
REQ-022 Latency: start sampled at edge N gives first word in cycle N+1, last word in N+length, done in N+length+1, and IDLE with a new start accepted in N+length+2.
REQ-023 Outside XFER: flag_write_hd=0, mem_write=0, and track/sector/mem_addr hold their last values.

Reset
REQ-024 reset=1 at a clock edge SHALL force IDLE, with busy, done, error, flag_write_hd and mem_write all 0, and track, sector, mem_addr, data_write, mem_data_write and the working counters all 0.
REQ-025 Reset SHALL override start and any in-flight transfer; no strobe SHALL be asserted in the cycle after the reset edge; a partial transfer is abandoned.

Verification
REQ-026 Load: track_in=0, sector_in=5, mem_base=16, length=4 -> mem_write high for 4 cycles, mem_addr 16..19, sector 5..8, data equals HD contents, then a one-cycle done.
REQ-027 Store: track_in=1, sector_in=149, length=4 -> flag_write_hd for 4 cycles at (1,149), (1,150), (2,0), (2,1), then done.
REQ-028 Track overflow: track_in=2, sector_in=150, length=3 -> one write at (2,150), then error pulse, no done, busy low after 2 more cycles.
REQ-029 length=0 -> no strobes, done exactly 1 cycle after start; out-of-range track_in=3 -> error pulse, no strobes.
REQ-030 reset asserted on the 3rd XFER cycle of length=10 -> next cycle all strobes/busy 0, outputs 0; a start 2 cycles later is accepted normally.
REQ-031 start held high across a whole transfer -> a second transfer begins only in the IDLE cycle after done (REQ-022 timing), and mem_base=1022 with length=4 wraps mem_addr through 1022, 1023, 0, 1.
